// File: rtl/aes_pkg.sv
// Shared AES widths, the byte type and the InvSubBytes sequencer state encoding.
package aes_pkg;
  localparam int AES_STATE_W = 128;
  localparam int AES_BYTES   = 16;

  typedef logic [7:0] aes_byte_t;

  typedef enum logic [1:0] {IDLE, PROC, DONE} inv_sb_state_t;
endpackage

// File: rtl/inv_sbox_unit.sv
// Combinational AES inverse S-box: a single byte lookup, fully enumerated.
module inv_sbox_unit
  import aes_pkg::*;
(
  input  aes_byte_t val,
  output aes_byte_t inv
);

  always_comb begin
    inv = 8'h00;
    case (val)
      8'h00: inv = 8'h52; 8'h01: inv = 8'h09; 8'h02: inv = 8'h6a; 8'h03: inv = 8'hd5;
      8'h04: inv = 8'h30; 8'h05: inv = 8'h36; 8'h06: inv = 8'ha5; 8'h07: inv = 8'h38;
      8'h08: inv = 8'hbf; 8'h09: inv = 8'h40; 8'h0a: inv = 8'ha3; 8'h0b: inv = 8'h9e;
      8'h0c: inv = 8'h81; 8'h0d: inv = 8'hf3; 8'h0e: inv = 8'hd7; 8'h0f: inv = 8'hfb;
      8'h10: inv = 8'h7c; 8'h11: inv = 8'he3; 8'h12: inv = 8'h39; 8'h13: inv = 8'h82;
      8'h14: inv = 8'h9b; 8'h15: inv = 8'h2f; 8'h16: inv = 8'hff; 8'h17: inv = 8'h87;
      8'h18: inv = 8'h34; 8'h19: inv = 8'h8e; 8'h1a: inv = 8'h43; 8'h1b: inv = 8'h44;
      8'h1c: inv = 8'hc4; 8'h1d: inv = 8'hde; 8'h1e: inv = 8'he9; 8'h1f: inv = 8'hcb;
      8'h20: inv = 8'h54; 8'h21: inv = 8'h7b; 8'h22: inv = 8'h94; 8'h23: inv = 8'h32;
      8'h24: inv = 8'ha6; 8'h25: inv = 8'hc2; 8'h26: inv = 8'h23; 8'h27: inv = 8'h3d;
      8'h28: inv = 8'hee; 8'h29: inv = 8'h4c; 8'h2a: inv = 8'h95; 8'h2b: inv = 8'h0b;
      8'h2c: inv = 8'h42; 8'h2d: inv = 8'hfa; 8'h2e: inv = 8'hc3; 8'h2f: inv = 8'h4e;
      8'h30: inv = 8'h08; 8'h31: inv = 8'h2e; 8'h32: inv = 8'ha1; 8'h33: inv = 8'h66;
      8'h34: inv = 8'h28; 8'h35: inv = 8'hd9; 8'h36: inv = 8'h24; 8'h37: inv = 8'hb2;
      8'h38: inv = 8'h76; 8'h39: inv = 8'h5b; 8'h3a: inv = 8'ha2; 8'h3b: inv = 8'h49;
      8'h3c: inv = 8'h6d; 8'h3d: inv = 8'h8b; 8'h3e: inv = 8'hd1; 8'h3f: inv = 8'h25;
      8'h40: inv = 8'h72; 8'h41: inv = 8'hf8; 8'h42: inv = 8'hf6; 8'h43: inv = 8'h64;
      8'h44: inv = 8'h86; 8'h45: inv = 8'h68; 8'h46: inv = 8'h98; 8'h47: inv = 8'h16;
      8'h48: inv = 8'hd4; 8'h49: inv = 8'ha4; 8'h4a: inv = 8'h5c; 8'h4b: inv = 8'hcc;
      8'h4c: inv = 8'h5d; 8'h4d: inv = 8'h65; 8'h4e: inv = 8'hb6; 8'h4f: inv = 8'h92;
      8'h50: inv = 8'h6c; 8'h51: inv = 8'h70; 8'h52: inv = 8'h48; 8'h53: inv = 8'h50;
      8'h54: inv = 8'hfd; 8'h55: inv = 8'hed; 8'h56: inv = 8'hb9; 8'h57: inv = 8'hda;
      8'h58: inv = 8'h5e; 8'h59: inv = 8'h15; 8'h5a: inv = 8'h46; 8'h5b: inv = 8'h57;
      8'h5c: inv = 8'ha7; 8'h5d: inv = 8'h8d; 8'h5e: inv = 8'h9d; 8'h5f: inv = 8'h84;
      8'h60: inv = 8'h90; 8'h61: inv = 8'hd8; 8'h62: inv = 8'hab; 8'h63: inv = 8'h00;
      8'h64: inv = 8'h8c; 8'h65: inv = 8'hbc; 8'h66: inv = 8'hd3; 8'h67: inv = 8'h0a;
      8'h68: inv = 8'hf7; 8'h69: inv = 8'he4; 8'h6a: inv = 8'h58; 8'h6b: inv = 8'h05;
      8'h6c: inv = 8'hb8; 8'h6d: inv = 8'hb3; 8'h6e: inv = 8'h45; 8'h6f: inv = 8'h06;
      8'h70: inv = 8'hd0; 8'h71: inv = 8'h2c; 8'h72: inv = 8'h1e; 8'h73: inv = 8'h8f;
      8'h74: inv = 8'hca; 8'h75: inv = 8'h3f; 8'h76: inv = 8'h0f; 8'h77: inv = 8'h02;
      8'h78: inv = 8'hc1; 8'h79: inv = 8'haf; 8'h7a: inv = 8'hbd; 8'h7b: inv = 8'h03;
      8'h7c: inv = 8'h01; 8'h7d: inv = 8'h13; 8'h7e: inv = 8'h8a; 8'h7f: inv = 8'h6b;
      8'h80: inv = 8'h3a; 8'h81: inv = 8'h91; 8'h82: inv = 8'h11; 8'h83: inv = 8'h41;
      8'h84: inv = 8'h4f; 8'h85: inv = 8'h67; 8'h86: inv = 8'hdc; 8'h87: inv = 8'hea;
      8'h88: inv = 8'h97; 8'h89: inv = 8'hf2; 8'h8a: inv = 8'hcf; 8'h8b: inv = 8'hce;
      8'h8c: inv = 8'hf0; 8'h8d: inv = 8'hb4; 8'h8e: inv = 8'he6; 8'h8f: inv = 8'h73;
      8'h90: inv = 8'h96; 8'h91: inv = 8'hac; 8'h92: inv = 8'h74; 8'h93: inv = 8'h22;
      8'h94: inv = 8'he7; 8'h95: inv = 8'had; 8'h96: inv = 8'h35; 8'h97: inv = 8'h85;
      8'h98: inv = 8'he2; 8'h99: inv = 8'hf9; 8'h9a: inv = 8'h37; 8'h9b: inv = 8'he8;
      8'h9c: inv = 8'h1c; 8'h9d: inv = 8'h75; 8'h9e: inv = 8'hdf; 8'h9f: inv = 8'h6e;
      8'ha0: inv = 8'h47; 8'ha1: inv = 8'hf1; 8'ha2: inv = 8'h1a; 8'ha3: inv = 8'h71;
      8'ha4: inv = 8'h1d; 8'ha5: inv = 8'h29; 8'ha6: inv = 8'hc5; 8'ha7: inv = 8'h89;
      8'ha8: inv = 8'h6f; 8'ha9: inv = 8'hb7; 8'haa: inv = 8'h62; 8'hab: inv = 8'h0e;
      8'hac: inv = 8'haa; 8'had: inv = 8'h18; 8'hae: inv = 8'hbe; 8'haf: inv = 8'h1b;
      8'hb0: inv = 8'hfc; 8'hb1: inv = 8'h56; 8'hb2: inv = 8'h3e; 8'hb3: inv = 8'h4b;
      8'hb4: inv = 8'hc6; 8'hb5: inv = 8'hd2; 8'hb6: inv = 8'h79; 8'hb7: inv = 8'h20;
      8'hb8: inv = 8'h9a; 8'hb9: inv = 8'hdb; 8'hba: inv = 8'hc0; 8'hbb: inv = 8'hfe;
      8'hbc: inv = 8'h78; 8'hbd: inv = 8'hcd; 8'hbe: inv = 8'h5a; 8'hbf: inv = 8'hf4;
      8'hc0: inv = 8'h1f; 8'hc1: inv = 8'hdd; 8'hc2: inv = 8'ha8; 8'hc3: inv = 8'h33;
      8'hc4: inv = 8'h88; 8'hc5: inv = 8'h07; 8'hc6: inv = 8'hc7; 8'hc7: inv = 8'h31;
      8'hc8: inv = 8'hb1; 8'hc9: inv = 8'h12; 8'hca: inv = 8'h10; 8'hcb: inv = 8'h59;
      8'hcc: inv = 8'h27; 8'hcd: inv = 8'h80; 8'hce: inv = 8'hec; 8'hcf: inv = 8'h5f;
      8'hd0: inv = 8'h60; 8'hd1: inv = 8'h51; 8'hd2: inv = 8'h7f; 8'hd3: inv = 8'ha9;
      8'hd4: inv = 8'h19; 8'hd5: inv = 8'hb5; 8'hd6: inv = 8'h4a; 8'hd7: inv = 8'h0d;
      8'hd8: inv = 8'h2d; 8'hd9: inv = 8'he5; 8'hda: inv = 8'h7a; 8'hdb: inv = 8'h9f;
      8'hdc: inv = 8'h93; 8'hdd: inv = 8'hc9; 8'hde: inv = 8'h9c; 8'hdf: inv = 8'hef;
      8'he0: inv = 8'ha0; 8'he1: inv = 8'he0; 8'he2: inv = 8'h3b; 8'he3: inv = 8'h4d;
      8'he4: inv = 8'hae; 8'he5: inv = 8'h2a; 8'he6: inv = 8'hf5; 8'he7: inv = 8'hb0;
      8'he8: inv = 8'hc8; 8'he9: inv = 8'heb; 8'hea: inv = 8'hbb; 8'heb: inv = 8'h3c;
      8'hec: inv = 8'h83; 8'hed: inv = 8'h53; 8'hee: inv = 8'h99; 8'hef: inv = 8'h61;
      8'hf0: inv = 8'h17; 8'hf1: inv = 8'h2b; 8'hf2: inv = 8'h04; 8'hf3: inv = 8'h7e;
      8'hf4: inv = 8'hba; 8'hf5: inv = 8'h77; 8'hf6: inv = 8'hd6; 8'hf7: inv = 8'h26;
      8'hf8: inv = 8'he1; 8'hf9: inv = 8'h69; 8'hfa: inv = 8'h14; 8'hfb: inv = 8'h63;
      8'hfc: inv = 8'h55; 8'hfd: inv = 8'h21; 8'hfe: inv = 8'h0c; 8'hff: inv = 8'h7d;
      default: inv = 8'h00;
    endcase
  end

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// Sequential AES InvSubBytes: one 128-bit state in, substituted BYTES_PER_CYCLE
// bytes per clock in place, result held on a valid/ready output.
//
// state | meaning
// IDLE  | waiting for a state, in_ready high
// PROC  | substituting one byte group per clock
// DONE  | result on data_out, out_valid high until out_ready
module inv_sub_bytes_seq
  import aes_pkg::*;
#(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_STATE_W-1:0] data_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] data_out,
  output logic                   busy
);

  localparam int NUM_STEPS = AES_BYTES / BYTES_PER_CYCLE;
  localparam int CNT_W     = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NUM_STEPS - 1);

  inv_sb_state_t          state;
  logic [CNT_W-1:0]       cnt;
  aes_byte_t              work     [AES_BYTES];
  aes_byte_t              work_nxt [AES_BYTES];
  aes_byte_t              sb_in    [BYTES_PER_CYCLE];
  aes_byte_t              sb_out   [BYTES_PER_CYCLE];
  logic [3:0]             grp_idx  [BYTES_PER_CYCLE];
  logic [AES_STATE_W-1:0] work_nxt_flat;

  // Byte g of the current group sits at index cnt*BPC + g of the working register.
  always_comb begin
    for (int g = 0; g < BYTES_PER_CYCLE; g++) begin
      grp_idx[g] = 4'(int'(cnt) * BYTES_PER_CYCLE + g);
      sb_in[g]   = work[grp_idx[g]];
    end
  end

  for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_sbox
    inv_sbox_unit u_sbox (
      .val (sb_in[g]),
      .inv (sb_out[g])
    );
  end

  always_comb begin
    work_nxt = work;
    for (int g = 0; g < BYTES_PER_CYCLE; g++) begin
      work_nxt[grp_idx[g]] = sb_out[g];
    end
  end

  always_comb begin
    work_nxt_flat = '0;
    for (int i = 0; i < AES_BYTES; i++) begin
      work_nxt_flat[AES_STATE_W-1-8*i -: 8] = work_nxt[i];
    end
  end

  // data_out is its own register so it keeps the last result while a new block runs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      cnt       <= '0;
      for (int i = 0; i < AES_BYTES; i++) work[i] <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      data_out  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < AES_BYTES; i++) work[i] <= data_in[AES_STATE_W-1-8*i -: 8];
            cnt      <= '0;
            state    <= PROC;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        PROC: begin
          work <= work_nxt;
          if (cnt == LAST_STEP) begin
            cnt       <= '0;
            state     <= DONE;
            out_valid <= 1'b1;
            data_out  <= work_nxt_flat;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Bench for inv_sub_bytes_seq: expected states come from the forward S-box
// round trip, queued on input handshake and popped when the result appears.
module tb_inv_sub_bytes_seq;

  logic         clk = 1'b0;
  logic         n_rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         sw_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] data_in = '0;

  logic         in_ready, out_valid, busy;
  logic [127:0] data_out;
  logic         s1_in_ready, s1_out_valid, s1_busy;
  logic [127:0] s1_data_out;
  logic         s16_in_ready, s16_out_valid, s16_busy;
  logic [127:0] s16_data_out;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [127:0] sb_q [$];
  logic [127:0] last_exp = '0;

  localparam logic [127:0] ID_CIPHER = 128'h637C777BF26B6FC53001672BFED7AB76;
  localparam logic [127:0] ID_PLAIN  = 128'h000102030405060708090A0B0C0D0E0F;

  logic [7:0] fwd_sbox [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  inv_sub_bytes_seq #(.BYTES_PER_CYCLE(4)) u_dut (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out), .busy(busy)
  );

  inv_sub_bytes_seq #(.BYTES_PER_CYCLE(1)) u_dut_bpc1 (
    .clk(clk), .n_rst(n_rst), .in_valid(sw_valid), .in_ready(s1_in_ready), .data_in(data_in),
    .out_valid(s1_out_valid), .out_ready(out_ready), .data_out(s1_data_out), .busy(s1_busy)
  );

  inv_sub_bytes_seq #(.BYTES_PER_CYCLE(16)) u_dut_bpc16 (
    .clk(clk), .n_rst(n_rst), .in_valid(sw_valid), .in_ready(s16_in_ready), .data_in(data_in),
    .out_valid(s16_out_valid), .out_ready(out_ready), .data_out(s16_data_out), .busy(s16_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [127:0] fwd_block(input logic [127:0] p);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = fwd_sbox[p[127-8*i -: 8]];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input string tag, input logic [127:0] d, input logic [127:0] exp);
    chk({tag, "_in_ready"}, 128'(in_ready), 128'(1));
    in_valid = 1'b1;
    data_in  = d;
    tick();
    in_valid = 1'b0;
    sb_q.push_back(exp);
  endtask

  task automatic wait_out(input string tag, input int exp_lat);
    int lat;
    logic [127:0] exp;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"}, 128'(lat), 128'(exp_lat));
    if (sb_q.size() > 0) exp = sb_q.pop_front();
    else exp = 'x;
    chk({tag, "_data"}, data_out, exp);
    last_exp = exp;
  endtask

  initial begin
    logic [127:0] plain;
    int prev_acc, l1, l16;
    logic [127:0] d1, d16;

    // reset values
    #12;
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_data_out", data_out, 128'h0);
    n_rst = 1'b1;
    out_ready = 1'b1;

    // identity vector
    send("ident", ID_CIPHER, ID_PLAIN);
    chk("ident_busy", 128'(busy), 128'(1));
    chk("ident_in_ready_low", 128'(in_ready), 128'(0));
    wait_out("ident", 4);
    tick();
    chk("ident_rel_valid", 128'(out_valid), 128'(0));
    chk("ident_rel_ready", 128'(in_ready), 128'(1));

    // named table corners
    send("corner", 128'h657A1663_00636363_63636363_63636363,
         128'hBCBDFF00_52000000_00000000_00000000);
    wait_out("corner", 4);
    tick();

    // all 256 table entries via forward S-box round trip
    for (int k = 0; k < 16; k++) begin
      plain = '0;
      for (int i = 0; i < 16; i++) plain[127-8*i -: 8] = 8'(16*k + i);
      send("exh", fwd_block(plain), plain);
      wait_out("exh", 4);
      tick();
    end

    // backpressure with an ignored second request
    out_ready = 1'b0;
    plain = {$urandom, $urandom, $urandom, $urandom};
    send("bp", fwd_block(plain), plain);
    wait_out("bp", 4);
    for (int k = 0; k < 10; k++) begin
      if (k == 2) begin
        in_valid = 1'b1;
        data_in  = ~data_in;
      end
      tick();
      chk("bp_hold_valid", 128'(out_valid), 128'(1));
      chk("bp_hold_data", data_out, last_exp);
      chk("bp_in_ready", 128'(in_ready), 128'(0));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_rel_ready", 128'(in_ready), 128'(1));
    chk("bp_rel_valid", 128'(out_valid), 128'(0));
    chk("bp_rel_busy", 128'(busy), 128'(0));
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("bp_no_second", 128'(out_valid), 128'(0));
    end
    chk("bp_data_hold", data_out, last_exp);

    // reset during the second PROC cycle
    plain = {$urandom, $urandom, $urandom, $urandom};
    send("mid", fwd_block(plain), plain);
    tick();
    n_rst = 1'b0;
    #1;
    chk("mid_rst_valid", 128'(out_valid), 128'(0));
    chk("mid_rst_data", data_out, 128'h0);
    chk("mid_rst_ready", 128'(in_ready), 128'(1));
    chk("mid_rst_busy", 128'(busy), 128'(0));
    sb_q.delete();
    #2;
    n_rst = 1'b1;
    send("after_rst", {16{8'h63}}, 128'h0);
    wait_out("after_rst", 4);
    tick();

    // back-to-back streaming, in_valid and out_ready held high
    in_valid  = 1'b1;
    prev_acc  = 0;
    for (int b = 0; b < 8; b++) begin
      plain   = {$urandom, $urandom, $urandom, $urandom};
      data_in = fwd_block(plain);
      chk("strm_in_ready", 128'(in_ready), 128'(1));
      tick();
      sb_q.push_back(plain);
      if (b > 0) chk("strm_period", 128'(cyc - prev_acc), 128'(6));
      prev_acc = cyc;
      wait_out("strm", 4);
      tick();
    end
    in_valid = 1'b0;
    chk("strm_queue_empty", 128'(sb_q.size()), 128'(0));

    // parameter sweep: BPC 1 and 16
    n_rst = 1'b0;
    #1;
    chk("sw1_rst_ready", 128'(s1_in_ready), 128'(1));
    chk("sw1_rst_valid", 128'(s1_out_valid), 128'(0));
    chk("sw1_rst_busy", 128'(s1_busy), 128'(0));
    chk("sw1_rst_data", s1_data_out, 128'h0);
    chk("sw16_rst_ready", 128'(s16_in_ready), 128'(1));
    chk("sw16_rst_valid", 128'(s16_out_valid), 128'(0));
    chk("sw16_rst_busy", 128'(s16_busy), 128'(0));
    chk("sw16_rst_data", s16_data_out, 128'h0);
    #2;
    n_rst    = 1'b1;
    sw_valid = 1'b1;
    data_in  = ID_CIPHER;
    tick();
    sw_valid = 1'b0;
    l1 = -1; l16 = -1; d1 = 'x; d16 = 'x;
    for (int t = 1; t <= 24; t++) begin
      if (s16_out_valid === 1'b1 && l16 < 0) begin l16 = t - 1; d16 = s16_data_out; end
      if (s1_out_valid === 1'b1 && l1 < 0) begin l1 = t - 1; d1 = s1_data_out; end
      tick();
    end
    chk("sw1_lat", 128'(l1), 128'(16));
    chk("sw1_data", d1, ID_PLAIN);
    chk("sw16_lat", 128'(l16), 128'(1));
    chk("sw16_data", d16, ID_PLAIN);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inv_sub_bytes_seq.md
Name: inv_sub_bytes_seq

Overview:
- Sequential AES-128 InvSubBytes stage for the decryption datapath.
- Accepts one 128-bit state over a valid/ready handshake.
- Substitutes every byte through the FIPS-197 inverse S-box, BYTES_PER_CYCLE bytes per clock, then presents the result on a valid/ready output.
- Sits between InvShiftRows and AddRoundKey in the decryption round; it is the inverse of the encryption-side byte substitution.

Parameters:
- BYTES_PER_CYCLE, 4, number of inverse S-box lookups per clock. Legal values: 1, 2, 4, 8, 16.
- NUM_STEPS, 16/BYTES_PER_CYCLE, derived localparam; processing cycles per block.

Ports:
- clk  input  1  system clock, rising edge.
- n_rst  input  1  asynchronous active-low reset.
- in_valid  input  1  data_in holds a valid state.
- in_ready  output  1  block can accept a state this cycle.
- data_in  input  128  ciphertext-side state. Byte i = data_in[127-8i -: 8], i = 0..15.
- out_valid  output  1  data_out holds a completed result.
- out_ready  input  1  downstream accepts data_out.
- data_out  output  128  InvSubBytes(data_in), same byte ordering as data_in.
- busy  output  1  high in PROC or DONE.

Behaviour:
- Reset (n_rst low, asynchronous):
  - state = IDLE, step counter = 0, internal register = 0.
  - in_ready = 1, out_valid = 0, busy = 0, data_out = 128'h0.
- FSM states: IDLE, PROC, DONE.
- IDLE:
  - in_ready = 1.
  - When in_valid && in_ready at edge T: latch data_in into the working register, counter = 0, go to PROC.
- PROC:
  - in_ready = 0.
  - Each cycle, bytes [counter*BPC .. counter*BPC+BPC-1] of the working register are replaced in place by their inverse S-box values; counter increments.
  - When counter = NUM_STEPS-1, the last group is written and the FSM goes to DONE.
  - Counter width is max(1, $clog2(NUM_STEPS)).
  - For BPC = 16, PROC lasts exactly one cycle.
- DONE:
  - out_valid = 1.
  - data_out is driven from the working register and stays stable while out_valid && !out_ready (backpressure is unbounded).
  - On out_valid && out_ready: go to IDLE, out_valid = 0.
  - in_ready returns high the following cycle. Accept and release never happen in the same cycle.
- Latency: input handshake at edge T gives out_valid high after edge T+NUM_STEPS (4 cycles at default). Throughput is one block per NUM_STEPS+2 cycles with out_ready held high.
- in_valid asserted outside IDLE is ignored; data_in is not sampled.
- data_out holds the last result after release until the next DONE. Only out_valid qualifies it.
- Reset mid-operation: in-flight block discarded, all outputs go to their reset values immediately; no partial result is ever flagged valid.
- Table content is the exact FIPS-197 inverse S-box for all 256 entries. Every entry must be the true inverse of the standard forward S-box, including:
  - InvSbox(8'h65) = 8'hBC
  - InvSbox(8'h7A) = 8'hBD
- Lookups are purely combinational. No X propagation for any 8-bit input; a default arm drives 8'h00 for lint only.

Decomposition:
- Package aes_pkg:
  - localparam AES_STATE_W = 128, AES_BYTES = 16.
  - typedef logic [7:0] aes_byte_t.
  - typedef enum logic [1:0] {IDLE, PROC, DONE} inv_sb_state_t.
- Sub-module inv_sbox_unit: 8-bit in, 8-bit out, combinational case table.
  - Instantiated BYTES_PER_CYCLE times via generate.
  - Each instance is fed by a mux selecting its byte from the working register by counter.

Test Plan:
- Identity vector: data_in = 128'h637C777BF26B6FC53001672BFED7AB76, out_ready = 1 -> data_out = 128'h000102030405060708090A0B0C0D0E0F. out_valid rises exactly 4 cycles after the input handshake.
- Exhaustive table: 16 blocks covering bytes 8'h00..8'hFF through the forward S-box, then this block -> original bytes. Specifically check 8'h65 -> 8'hBC, 8'h7A -> 8'hBD, 8'h16 -> 8'hFF, 8'h63 -> 8'h00, 8'h00 -> 8'h52.
- Backpressure: hold out_ready = 0 for 10 cycles after out_valid -> out_valid and data_out stable. in_ready = 0 and a second in_valid is not accepted. Release out_ready -> in_ready = 1 the next cycle.
- Reset mid-operation: assert n_rst low during the 2nd PROC cycle -> out_valid = 0, data_out = 0, in_ready = 1 asynchronously. The next block (all 8'h63) yields all 8'h00.
- Back-to-back streaming with in_valid and out_ready held high, 8 random blocks -> results match a reference model in order, with a period of 6 cycles each.
- Parameter sweep: BYTES_PER_CYCLE = 1 and 16 with the identity vector -> same data_out; out_valid latency 16 and 1 cycles respectively.
